// File: rtl/front_panel_pkg.sv
// rtl/front_panel_pkg.sv - shared states, opcodes and command priority for the front panel sequencer
package front_panel_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RUNNING,
    STOPPING,
    STEP,
    EXM_OP,
    EXM_LO,
    EXM_HI,
    EXN_NOP,
    DEP_WR
  } state_t;

  localparam logic [7:0] OP_JMP = 8'hC3;
  localparam logic [7:0] OP_NOP = 8'h00;

  // Bit positions in the command edge vector; a lower index wins.
  localparam int NUM_CMD  = 7;
  localparam int PRI_STOP = 0;
  localparam int PRI_EXM  = 1;
  localparam int PRI_EXN  = 2;
  localparam int PRI_DEP  = 3;
  localparam int PRI_DPN  = 4;
  localparam int PRI_STEP = 5;
  localparam int PRI_RUN  = 6;

  // Keep only the highest-priority edge; the rest are dropped, not queued.
  function automatic logic [NUM_CMD-1:0] pick_cmd(input logic [NUM_CMD-1:0] edges);
    return edges & (~edges + NUM_CMD'(1));
  endfunction

endpackage

// File: rtl/sw_edge_det.sv
// rtl/sw_edge_det.sv - registered rising-edge detector, masked for the first cycle after reset
module sw_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] q;
  logic         armed;

  // armed stays low one cycle so levels already high at reset never count as edges
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      armed <= 1'b0;
    end else begin
      q     <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed ? (d & ~q) : '0;

endmodule

// File: rtl/front_panel_ctrl.sv
// rtl/front_panel_ctrl.sv - front panel FSM: run/stop/step, examine and deposit via jammed opcodes
module front_panel_ctrl
  import front_panel_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_run,
  input  logic        sw_stop,
  input  logic        sw_step,
  input  logic        sw_exm,
  input  logic        sw_exn,
  input  logic        sw_dep,
  input  logic        sw_dpn,
  input  logic [15:0] addr_sw,
  input  logic [7:0]  data_sw,
  input  logic        cpu_rd,
  input  logic        cpu_m1,
  output logic        cpu_ready,
  output logic        jam_en,
  output logic [7:0]  jam_data,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        running,
  output logic        busy,
  output logic        timeout_err
);

  state_t               state;
  state_t               nxt;
  logic [NUM_CMD-1:0]   sw_rise;
  logic [NUM_CMD-1:0]   cmd;
  logic                 rd_rise;
  logic [TW-1:0]        cnt;
  logic [15:0]          addr_q;
  logic                 dpn_flag;
  logic                 timed;
  logic                 tmo;
  logic                 accept;

  sw_edge_det #(.W(NUM_CMD)) u_sw_edge (
    .clk   (clk),
    .reset (reset),
    .d     ({sw_run, sw_step, sw_dpn, sw_dep, sw_exn, sw_exm, sw_stop}),
    .rise  (sw_rise)
  );

  sw_edge_det #(.W(1)) u_rd_edge (
    .clk   (clk),
    .reset (reset),
    .d     (cpu_rd),
    .rise  (rd_rise)
  );

  assign cmd = pick_cmd(sw_rise);

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    tmo    = 1'b0;
    timed  = (state inside {STOPPING, STEP, EXM_OP, EXM_LO, EXM_HI, EXN_NOP});
    case (state)
      IDLE: begin
        accept = (|cmd) & ~cmd[PRI_STOP];
        if (cmd[PRI_EXM])       nxt = EXM_OP;
        else if (cmd[PRI_EXN])  nxt = EXN_NOP;
        else if (cmd[PRI_DEP])  nxt = DEP_WR;
        else if (cmd[PRI_DPN])  nxt = EXN_NOP;
        else if (cmd[PRI_STEP]) nxt = STEP;
        else if (cmd[PRI_RUN])  nxt = RUNNING;
      end
      RUNNING: begin
        if (cmd[PRI_STOP]) begin
          nxt    = STOPPING;
          accept = 1'b1;
        end
      end
      STOPPING: if (rd_rise && cpu_m1) nxt = IDLE;
      STEP:     if (rd_rise && cpu_m1) nxt = STOPPING;
      EXM_OP:   if (rd_rise) nxt = EXM_LO;
      EXM_LO:   if (rd_rise) nxt = EXM_HI;
      EXM_HI:   if (rd_rise) nxt = IDLE;
      EXN_NOP:  if (rd_rise) nxt = dpn_flag ? DEP_WR : IDLE;
      DEP_WR:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    // A read edge in the same cycle as expiry counts as progress, not a timeout.
    if (timed && !rd_rise && cnt == TW'(TIMEOUT - 1)) begin
      tmo = 1'b1;
      nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      dpn_flag    <= 1'b0;
      cpu_ready   <= 1'b0;
      jam_en      <= 1'b0;
      jam_data    <= 8'h00;
      mem_we      <= 1'b0;
      mem_wdata   <= 8'h00;
      running     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state || rd_rise) ? '0 : cnt + TW'(1);

      if (state == IDLE && cmd[PRI_EXM]) addr_q <= addr_sw;

      if (state == IDLE && cmd[PRI_DPN])  dpn_flag <= 1'b1;
      else if (state == DEP_WR || tmo)    dpn_flag <= 1'b0;

      if (tmo)         timeout_err <= 1'b1;
      else if (accept) timeout_err <= 1'b0;

      if (nxt == DEP_WR) mem_wdata <= data_sw;

      // Outputs decode the state being entered so they line up with it.
      cpu_ready <= (nxt inside {RUNNING, STOPPING, STEP, EXM_OP, EXM_LO, EXM_HI, EXN_NOP});
      jam_en    <= (nxt inside {EXM_OP, EXM_LO, EXM_HI, EXN_NOP});
      mem_we    <= (nxt == DEP_WR);
      running   <= (nxt == RUNNING);
      busy      <= !(nxt inside {IDLE, RUNNING});
      case (nxt)
        EXM_OP:  jam_data <= OP_JMP;
        EXM_LO:  jam_data <= addr_q[7:0];
        EXM_HI:  jam_data <= addr_q[15:8];
        default: jam_data <= OP_NOP;
      endcase
    end
  end

endmodule
